// File: rtl/axi_to_mem_slave.sv
// AXI4 slave that serialises one burst at a time into single-beat MEM requests.
// Reads and writes share one FSM; read/write alternate when both address channels are valid.
module axi_to_mem_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                    mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata_i,
  input  logic                    mem_rsp_error_i,
  output logic [2:0]              dbg_state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready;
  // valid is never withdrawn by this block once raised, ready may be combinational.
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam logic [2:0] MAX_SIZE = 3'(OFF_W);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, RD_DATA, WR_DATA, WR_REQ, WR_WAIT, WR_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q, beat_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q, rd_prio_q;
  logic [DATA_WIDTH-1:0] rdata_q, wdata_q;
  logic [STRB_W-1:0]     wstrb_q;

  logic sel_rd, sel_wr, ar_oversize, aw_oversize, oversize, last_beat;

  assign sel_rd      = s_axi_arvalid && (!s_axi_awvalid || rd_prio_q);
  assign sel_wr      = s_axi_awvalid && !sel_rd;
  assign ar_oversize = s_axi_arsize > MAX_SIZE;
  assign aw_oversize = s_axi_awsize > MAX_SIZE;
  assign oversize    = size_q > MAX_SIZE;
  assign last_beat   = beat_q == len_q;

  // WRAP keeps the upper address bits and lets the low bits roll inside the burst window.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [7:0] len,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, mask;
    step = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'd0:    next_addr = addr;
      2'd2:    next_addr = (addr & ~mask) | ((addr + step) & mask);
      default: next_addr = addr + step;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    s_axi_arready = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_bvalid  = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_be_o      = '0;
    case (state_q)
      IDLE: begin
        s_axi_arready = sel_rd;
        s_axi_awready = sel_wr;
        if (sel_rd)      state_d = ar_oversize ? RD_DATA : RD_REQ;
        else if (sel_wr) state_d = WR_DATA;
      end
      RD_REQ: begin
        mem_req_o = 1'b1;
        mem_be_o  = '1;
        if (mem_gnt_i) state_d = RD_WAIT;
      end
      RD_WAIT: if (mem_rsp_valid_i) state_d = RD_DATA;
      RD_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) begin
          if (last_beat)     state_d = IDLE;
          else if (oversize) state_d = RD_DATA;
          else               state_d = RD_REQ;
        end
      end
      WR_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          if (!oversize)      state_d = WR_REQ;
          else if (last_beat) state_d = WR_RESP;
        end
      end
      WR_REQ: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        mem_be_o  = wstrb_q;
        if (mem_gnt_i) state_d = WR_WAIT;
      end
      WR_WAIT: if (mem_rsp_valid_i) state_d = last_beat ? WR_RESP : WR_DATA;
      WR_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      rd_prio_q <= 1'b1;
      rdata_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_rd) begin
            id_q      <= s_axi_arid;
            addr_q    <= s_axi_araddr;
            len_q     <= s_axi_arlen;
            size_q    <= s_axi_arsize;
            burst_q   <= s_axi_arburst;
            beat_q    <= '0;
            err_q     <= ar_oversize;
            rdata_q   <= '0;
            rd_prio_q <= 1'b0;
          end else if (sel_wr) begin
            id_q      <= s_axi_awid;
            addr_q    <= s_axi_awaddr;
            len_q     <= s_axi_awlen;
            size_q    <= s_axi_awsize;
            burst_q   <= s_axi_awburst;
            beat_q    <= '0;
            err_q     <= aw_oversize;
            rd_prio_q <= 1'b1;
          end
        end
        RD_WAIT: if (mem_rsp_valid_i) begin
          rdata_q <= mem_rsp_rdata_i;
          err_q   <= mem_rsp_error_i;
        end
        RD_DATA: if (s_axi_rready && !last_beat) begin
          addr_q <= next_addr(addr_q, len_q, size_q, burst_q);
          beat_q <= beat_q + 8'd1;
        end
        WR_DATA: if (s_axi_wvalid) begin
          wdata_q <= s_axi_wdata;
          wstrb_q <= s_axi_wstrb;
          if (s_axi_wlast != last_beat) err_q <= 1'b1;
          if (oversize && !last_beat) begin
            addr_q <= next_addr(addr_q, len_q, size_q, burst_q);
            beat_q <= beat_q + 8'd1;
          end
        end
        WR_WAIT: if (mem_rsp_valid_i) begin
          if (mem_rsp_error_i) err_q <= 1'b1;
          if (!last_beat) begin
            addr_q <= next_addr(addr_q, len_q, size_q, burst_q);
            beat_q <= beat_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr_o  = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_wdata_o = wdata_q;
  assign s_axi_rid   = id_q;
  assign s_axi_bid   = id_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = (state_q == RD_DATA && err_q) ? 2'b10 : 2'b00;
  assign s_axi_rlast = (state_q == RD_DATA) && last_beat;
  assign s_axi_bresp = (state_q == WR_RESP && err_q) ? 2'b10 : 2'b00;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi_to_mem_slave.sv
// Directed bench for axi_to_mem_slave: AXI driver tasks, a MEM responder with
// grant delay / error injection, and an access scoreboard.
module tb_axi_to_mem_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid, s_axi_bresp, s_axi_rresp;
  logic [1:0]  s_axi_awburst, s_axi_arburst;
  logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize, dbg_state;
  logic [3:0]  s_axi_wstrb, mem_be;
  logic s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic mem_req, mem_gnt, mem_we, mem_rsp_valid, mem_rsp_error;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_rdata;

  axi_to_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_rdata_i(mem_rsp_rdata), .mem_rsp_error_i(mem_rsp_error),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // MEM responder: grant after gnt_delay cycles of req, respond one cycle later.
  logic [31:0] mem_model [0:255];
  logic [36:0] log_q[$];
  logic [36:0] exp_q[$];
  int  gnt_delay = 0, err_at = -1, acc_idx = 0, wait_cnt = 0;
  bit  hold_rsp = 0, pend = 0, pend_err = 0;
  logic [31:0] pend_data;

  initial begin : responder
    for (int k = 0; k < 256; k++) mem_model[k] = 32'hC0DE_0000 + 32'(k * 4);
    mem_gnt = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0; mem_rsp_error = 0;
    forever begin
      @(posedge clk); #2;
      mem_gnt = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0; mem_rsp_error = 0;
      if (rst) begin
        pend = 0; wait_cnt = 0;
      end else if (pend) begin
        if (!hold_rsp) begin
          mem_rsp_valid = 1; mem_rsp_rdata = pend_data; mem_rsp_error = pend_err; pend = 0;
        end
      end else if (mem_req) begin
        if (wait_cnt >= gnt_delay) begin
          mem_gnt = 1; wait_cnt = 0; pend = 1;
          pend_err = (acc_idx == err_at);
          acc_idx++;
          log_q.push_back({mem_be, mem_we, mem_addr});
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_be[b]) mem_model[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            pend_data = 32'h0;
          end else pend_data = mem_model[mem_addr[9:2]];
        end else wait_cnt++;
      end
    end
  end

  task automatic push_exp(input logic [3:0] be, input logic we, input logic [31:0] addr);
    exp_q.push_back({be, we, addr});
  endtask

  task automatic sb_drain(input string tag);
    logic [36:0] e, o;
    check({tag, "_count"}, log_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (log_q.size() > 0) ? log_q.pop_front() : 'x;
      check(tag, o, e);
    end
    log_q.delete();
  endtask

  // AXI driver tasks; inputs change 1 time unit after posedge, outputs sampled at negedge.
  int t_hs, first_cyc;
  logic [31:0] rd_data_q[$];
  logic [1:0]  rd_resp_q[$], rd_id_q[$];
  logic        rd_last_q[$];
  logic [1:0]  b_resp, b_id;

  task automatic ar_wait();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axi_arready) begin ok = 1; break; end
    end
    t_hs = cyc;
    @(posedge clk); #1 s_axi_arvalid = 0;
    check("ar_handshake", ok, 1);
  endtask

  task automatic ar_phase(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    @(posedge clk); #1;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1;
    ar_wait();
  endtask

  task automatic r_phase(input int len, input int stall);
    int beats = 0;
    rd_data_q.delete(); rd_resp_q.delete(); rd_last_q.delete(); rd_id_q.delete();
    first_cyc = -1;
    s_axi_rready = (stall == 0);
    for (int i = 0; i < 300 && beats <= len; i++) begin
      @(negedge clk);
      if (s_axi_rvalid && first_cyc < 0) first_cyc = cyc;
      if (s_axi_rvalid && s_axi_rready) begin
        rd_data_q.push_back(s_axi_rdata); rd_resp_q.push_back(s_axi_rresp);
        rd_last_q.push_back(s_axi_rlast); rd_id_q.push_back(s_axi_rid);
        beats++;
      end else if (s_axi_rvalid && stall > 0) stall--;
      @(posedge clk); #1 s_axi_rready = (stall == 0) && (beats <= len);
    end
    s_axi_rready = 0;
    check("r_beats", beats, len + 1);
  endtask

  task automatic aw_wait();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axi_awready) begin ok = 1; break; end
    end
    @(posedge clk); #1 s_axi_awvalid = 0;
    check("aw_handshake", ok, 1);
  endtask

  task automatic aw_phase(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    @(posedge clk); #1;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1;
    aw_wait();
  endtask

  task automatic w_phase(input int len, input logic [31:0] base, input logic [3:0] strb, input int bad_last);
    int acc = 0;
    for (int i = 0; i <= len; i++) begin
      s_axi_wvalid = 1; s_axi_wdata = base + 32'(i); s_axi_wstrb = strb;
      s_axi_wlast = (i == len) != (i == bad_last);
      for (int j = 0; j < 200; j++) begin
        @(negedge clk);
        if (s_axi_wready) begin acc++; break; end
      end
      @(posedge clk); #1;
    end
    s_axi_wvalid = 0; s_axi_wlast = 0;
    check("w_beats", acc, len + 1);
  endtask

  task automatic b_phase();
    bit ok = 0;
    s_axi_bready = 1;
    b_resp = 2'bxx; b_id = 2'bxx;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axi_bvalid) begin ok = 1; b_resp = s_axi_bresp; b_id = s_axi_bid; break; end
    end
    @(posedge clk); #1 s_axi_bready = 0;
    check("b_handshake", ok, 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int wrap_a [4] = '{'h38, 'h3C, 'h30, 'h34};
    s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 0; s_axi_awburst = 0;
    s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0; s_axi_wvalid = 0;
    s_axi_bready = 0; s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 0;
    s_axi_arburst = 0; s_axi_arvalid = 0; s_axi_rready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Reset state
    @(negedge clk);
    check("rst_state", dbg_state, 0);
    check("rst_arready", s_axi_arready, 0);
    check("rst_awready", s_axi_awready, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_rdata", s_axi_rdata, 0);

    // Single read with latency check
    mem_model['h40] = 32'hDEAD_BEEF;
    ar_phase(1, 'h100, 0, 2, 1);
    r_phase(0, 0);
    check("t1_latency", first_cyc - t_hs, 3);
    check("t1_data", rd_data_q[0], 32'hDEAD_BEEF);
    check("t1_resp", rd_resp_q[0], 0);
    check("t1_last", rd_last_q[0], 1);
    check("t1_id", rd_id_q[0], 1);
    push_exp(4'hF, 0, 'h100);
    sb_drain("t1_mem");

    // INCR write
    aw_phase(2, 'h40, 3, 2, 1);
    w_phase(3, 32'h1111_0000, 4'hF, -1);
    b_phase();
    check("t2_bresp", b_resp, 0);
    check("t2_bid", b_id, 2);
    for (int i = 0; i < 4; i++) push_exp(4'hF, 1, 32'h40 + 32'(4 * i));
    sb_drain("t2_mem");
    for (int i = 0; i < 4; i++) check("t2_wdata", mem_model[16 + i], 32'h1111_0000 + 32'(i));

    // WRAP read
    ar_phase(3, 'h38, 3, 2, 2);
    r_phase(3, 0);
    for (int i = 0; i < 4; i++) begin
      check("t3_data", rd_data_q[i], 32'hC0DE_0000 + 32'(wrap_a[i]));
      check("t3_last", rd_last_q[i], i == 3);
      push_exp(4'hF, 0, 32'(wrap_a[i]));
    end
    check("t3_id", rd_id_q[3], 3);
    sb_drain("t3_mem");

    // FIXED read repeats the address
    ar_phase(0, 'h20, 1, 2, 0);
    r_phase(1, 0);
    check("fix_data0", rd_data_q[0], 32'hC0DE_0020);
    check("fix_data1", rd_data_q[1], 32'hC0DE_0020);
    push_exp(4'hF, 0, 'h20); push_exp(4'hF, 0, 'h20);
    sb_drain("fix_mem");

    // Error on beat 1 of a write, partial strobes
    err_at = acc_idx + 1;
    aw_phase(1, 'h60, 1, 2, 1);
    w_phase(1, 32'h2222_0000, 4'h6, -1);
    b_phase();
    check("t4w_bresp", b_resp, 2);
    check("t4w_bid", b_id, 1);
    check("t4w_strb_merge", mem_model[24], 32'hC022_0060);
    push_exp(4'h6, 1, 'h60); push_exp(4'h6, 1, 'h64);
    sb_drain("t4w_mem");

    // Error on beat 1 of a read
    err_at = acc_idx + 1;
    ar_phase(2, 'h70, 1, 2, 1);
    r_phase(1, 0);
    check("t4r_resp0", rd_resp_q[0], 0);
    check("t4r_resp1", rd_resp_q[1], 2);
    check("t4r_data0", rd_data_q[0], 32'hC0DE_0070);
    push_exp(4'hF, 0, 'h70); push_exp(4'hF, 0, 'h74);
    sb_drain("t4r_mem");
    err_at = -1;

    // Oversize read and write: no MEM traffic, SLVERR
    ar_phase(3, 'h80, 1, 3, 1);
    r_phase(1, 0);
    check("ovr_data", rd_data_q[0], 0);
    check("ovr_resp0", rd_resp_q[0], 2);
    check("ovr_resp1", rd_resp_q[1], 2);
    check("ovr_last", {rd_last_q[0], rd_last_q[1]}, 2'b01);
    sb_drain("ovr_mem");
    aw_phase(0, 'h90, 1, 3, 1);
    w_phase(1, 32'h4444_0000, 4'hF, -1);
    b_phase();
    check("ovw_bresp", b_resp, 2);
    sb_drain("ovw_mem");

    // Early wlast: both beats still written, SLVERR
    aw_phase(1, 'hA0, 1, 2, 1);
    w_phase(1, 32'h3333_0000, 4'hF, 0);
    b_phase();
    check("wlast_bresp", b_resp, 2);
    push_exp(4'hF, 1, 'hA0); push_exp(4'hF, 1, 'hA4);
    sb_drain("wlast_mem");

    // Arbitration with delayed grant and R backpressure
    gnt_delay = 4;
    @(posedge clk); #1;
    s_axi_arid = 2; s_axi_araddr = 'h80; s_axi_arlen = 1; s_axi_arsize = 2; s_axi_arburst = 1;
    s_axi_awid = 3; s_axi_awaddr = 'hC0; s_axi_awlen = 0; s_axi_awsize = 2; s_axi_awburst = 1;
    s_axi_arvalid = 1; s_axi_awvalid = 1;
    @(negedge clk);
    check("t5_arready1", s_axi_arready, 1);
    check("t5_awready1", s_axi_awready, 0);
    @(posedge clk); #1 s_axi_arvalid = 0;
    r_phase(1, 3);
    check("t5_rdata0", rd_data_q[0], 32'hC0DE_0080);
    check("t5_rdata1", rd_data_q[1], 32'hC0DE_0084);
    s_axi_arid = 0; s_axi_araddr = 'h88; s_axi_arlen = 0; s_axi_arvalid = 1;
    @(negedge clk);
    check("t5_arready2", s_axi_arready, 0);
    check("t5_awready2", s_axi_awready, 1);
    @(posedge clk); #1 s_axi_awvalid = 0;
    w_phase(0, 32'h5555_AAAA, 4'hF, -1);
    b_phase();
    check("t5_bid", b_id, 3);
    check("t5_bresp", b_resp, 0);
    ar_wait();
    r_phase(0, 0);
    check("t5_rdata2", rd_data_q[0], 32'hC0DE_0088);
    check("t5_rid", rd_id_q[0], 0);
    push_exp(4'hF, 0, 'h80); push_exp(4'hF, 0, 'h84);
    push_exp(4'hF, 1, 'hC0); push_exp(4'hF, 0, 'h88);
    sb_drain("t5_mem");
    check("t5_wdata", mem_model['h30], 32'h5555_AAAA);
    gnt_delay = 0;

    // Reset while waiting for a write response
    aw_phase(1, 'hD0, 1, 2, 1);
    hold_rsp = 1;
    s_axi_wvalid = 1; s_axi_wdata = 32'h7777_0000; s_axi_wstrb = 4'hF; s_axi_wlast = 0;
    @(negedge clk);
    check("t6_wready", s_axi_wready, 1);
    @(posedge clk); #1 s_axi_wvalid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t6_wr_wait", dbg_state, 6);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; hold_rsp = 0;
    @(negedge clk);
    check("t6_state", dbg_state, 0);
    check("t6_mem_req", mem_req, 0);
    check("t6_wready_off", s_axi_wready, 0);
    check("t6_bvalid", s_axi_bvalid, 0);
    check("t6_bid", s_axi_bid, 0);
    push_exp(4'hF, 1, 'hD0);
    sb_drain("t6_mem");
    ar_phase(2, 'h100, 0, 2, 1);
    r_phase(0, 0);
    check("t6_latency", first_cyc - t_hs, 3);
    check("t6_rdata", rd_data_q[0], 32'hDEAD_BEEF);
    check("t6_rresp", rd_resp_q[0], 0);
    push_exp(4'hF, 0, 'h100);
    sb_drain("t6_mem2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
